// File: rtl/shared_reg_arbiter.sv
// Round-robin owner of one shared WIDTH-bit register, single or locked writes.
// Optional forced release after TIMEOUT owned cycles: define ARB_TIMEOUT_EN.
module shared_reg_arbiter #(
  parameter int N_REQ   = 4,
  parameter int WIDTH   = 8,
  parameter int TIMEOUT = 16
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [N_REQ-1:0]           req,
  input  logic [N_REQ-1:0]           lock,
  input  logic [N_REQ-1:0]           wr_en,
  input  logic [N_REQ*WIDTH-1:0]     wr_data,
  output logic [N_REQ-1:0]           gnt,
  output logic [$clog2(N_REQ)-1:0]   owner,
  output logic [WIDTH-1:0]           q,
  output logic                       q_valid,
  output logic                       busy,
  output logic                       timeout_evt
);

  localparam int IW = $clog2(N_REQ);

  typedef enum logic {
    IDLE,
    OWNED
  } state_t;

  state_t          state;
  logic [IW-1:0]   rr_ptr;
  logic [IW-1:0]   pick;
  logic            pick_vld;
  logic [IW-1:0]   nxt_ptr;
  logic            own_req;
  logic            own_lock;
  logic            own_wr;
  logic [WIDTH-1:0] own_data;
  logic            tmo;
  logic            rel;

  // Reject configurations the arbiter was never meant to cover.
  if (N_REQ < 2 || N_REQ > 8 || TIMEOUT < 1) begin : g_bad_cfg
    $error("shared_reg_arbiter: bad N_REQ or TIMEOUT");
  end

  // First requester at or after rr_ptr, wrapping; lowest offset wins.
  always_comb begin
    pick     = '0;
    pick_vld = 1'b0;
    for (int k = N_REQ - 1; k >= 0; k--) begin
      if (req[(int'(rr_ptr) + k) % N_REQ]) begin
        pick     = IW'((int'(rr_ptr) + k) % N_REQ);
        pick_vld = 1'b1;
      end
    end
  end

  assign own_req  = req[owner];
  assign own_lock = lock[owner];
  assign own_wr   = wr_en[owner];
  assign own_data = wr_data[int'(owner)*WIDTH +: WIDTH];
  assign nxt_ptr  = (owner == IW'(N_REQ - 1)) ? '0 : owner + 1'b1;

`ifdef ARB_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT) + 1;
  logic [CW-1:0] cnt;
  assign tmo = (cnt == CW'(TIMEOUT - 1));
`else
  assign tmo         = 1'b0;
  assign timeout_evt = 1'b0;
`endif

  // A single-write owner leaves after its write; a locked one stays.
  assign rel = !own_req || (!own_lock && own_wr) || tmo;

  // Arbitration FSM with registered grant, owner and shared register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      gnt     <= '0;
      owner   <= '0;
      rr_ptr  <= '0;
      q       <= '0;
      q_valid <= 1'b0;
      busy    <= 1'b0;
`ifdef ARB_TIMEOUT_EN
      cnt         <= '0;
      timeout_evt <= 1'b0;
`endif
    end else begin
`ifdef ARB_TIMEOUT_EN
      timeout_evt <= 1'b0;
`endif
      unique case (state)
        IDLE: begin
          if (pick_vld) begin
            state <= OWNED;
            gnt   <= N_REQ'(1) << pick;
            owner <= pick;
            busy  <= 1'b1;
`ifdef ARB_TIMEOUT_EN
            cnt <= '0;
`endif
          end
        end
        OWNED: begin
          if (own_wr) begin
            q       <= own_data;
            q_valid <= 1'b1;
          end
          if (rel) begin
            state  <= IDLE;
            gnt    <= '0;
            busy   <= 1'b0;
            rr_ptr <= nxt_ptr;
`ifdef ARB_TIMEOUT_EN
            timeout_evt <= tmo;
`endif
          end
`ifdef ARB_TIMEOUT_EN
          else begin
            cnt <= cnt + 1'b1;
          end
`endif
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_shared_reg_arbiter.sv
// Randomized and directed check of shared_reg_arbiter against a
// transaction-level model of ownership, writes and round-robin order.
module tb_shared_reg_arbiter;

`ifdef ARB_TIMEOUT_EN
  localparam bit TMO_EN = 1'b1;
`else
  localparam bit TMO_EN = 1'b0;
`endif
  localparam int TIMEOUT = 16;

  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  req;
  logic [3:0]  lock;
  logic [3:0]  wr_en;
  logic [31:0] wr_data;
  logic [3:0]  gnt;
  logic [1:0]  owner;
  logic [7:0]  q;
  logic        q_valid;
  logic        busy;
  logic        timeout_evt;

  int n_cmp = 0;
  int n_err = 0;

  // model: who owns the register (-1 = nobody), how long, and history
  int       m_cur;
  int       m_ptr;
  int       m_owner;
  int       m_held;
  logic [7:0] m_q;
  logic     m_qv;
  logic     m_evt;

  shared_reg_arbiter #(
    .N_REQ(4), .WIDTH(8), .TIMEOUT(TIMEOUT)
  ) dut (
    .clk(clk), .rst(rst), .req(req), .lock(lock),
    .wr_en(wr_en), .wr_data(wr_data), .gnt(gnt),
    .owner(owner), .q(q), .q_valid(q_valid),
    .busy(busy), .timeout_evt(timeout_evt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // One clock edge of the ownership rules, from the sampled inputs.
  task automatic model_edge();
    int  i;
    bit  expire;
    bit  leave;
    m_evt = 1'b0;
    if (rst) begin
      m_cur = -1; m_ptr = 0; m_owner = 0; m_held = 0;
      m_q = 8'h00; m_qv = 1'b0;
    end else if (m_cur < 0) begin
      for (int k = 0; k < 4; k++) begin
        i = (m_ptr + k) % 4;
        if (req[i] && m_cur < 0) begin
          m_cur = i; m_owner = i; m_held = 0;
        end
      end
    end else begin
      i = m_cur;
      if (wr_en[i]) begin
        m_q  = wr_data[i*8 +: 8];
        m_qv = 1'b1;
      end
      expire = TMO_EN && (m_held == TIMEOUT - 1);
      leave  = !req[i] || (!lock[i] && wr_en[i]) || expire;
      if (leave) begin
        m_ptr = (i + 1) % 4;
        m_cur = -1;
        m_evt = expire;
      end else begin
        m_held++;
      end
    end
  endtask

  task automatic compare_all();
    logic [3:0] eg;
    eg = (m_cur < 0) ? 4'b0000 : 4'(1 << m_cur);
    chk("gnt", 32'(gnt), 32'(eg));
    chk("owner", 32'(owner), 32'(m_owner));
    chk("q", 32'(q), 32'(m_q));
    chk("q_valid", 32'(q_valid), 32'(m_qv));
    chk("busy", 32'(busy), 32'(m_cur >= 0));
    chk("timeout_evt", 32'(timeout_evt), 32'(m_evt));
    chk("onehot", 32'($onehot0(gnt)), 32'd1);
  endtask

  task automatic step(input logic r, input logic [3:0] rq,
                      input logic [3:0] lk, input logic [3:0] we,
                      input logic [31:0] d);
    rst = r; req = rq; lock = lk; wr_en = we; wr_data = d;
    @(posedge clk);
    model_edge();
    @(negedge clk);
    compare_all();
  endtask

  initial begin
    rst = 1'b1; req = '0; lock = '0; wr_en = '0; wr_data = '0;
    m_cur = -1; m_ptr = 0; m_owner = 0; m_held = 0;
    m_q = '0; m_qv = 1'b0; m_evt = 1'b0;
    @(negedge clk);

    // reset with random inputs
    repeat (2) step(1'b1, 4'($urandom), 4'($urandom), 4'($urandom), $urandom);
    chk("rst_gnt", 32'(gnt), 32'h0);
    chk("rst_q", 32'(q), 32'h0);

    // single write
    step(1'b0, 4'b0001, 4'b0000, 4'b0001, 32'h0000_00A5);
    chk("sw_gnt", 32'(gnt), 32'h1);
    step(1'b0, 4'b0001, 4'b0000, 4'b0001, 32'h0000_00A5);
    chk("sw_q", 32'(q), 32'hA5);
    chk("sw_qv", 32'(q_valid), 32'h1);
    chk("sw_rel", 32'(gnt), 32'h0);

    // round robin: each owner writes 0x10+i
    step(1'b1, 4'b0000, 4'b0000, 4'b0000, 32'h0);
    for (int i = 0; i < 4; i++) begin
      step(1'b0, 4'b1111, 4'b0000, 4'b1111, 32'h1312_1110);
      chk("rr_gnt", 32'(gnt), 32'(1 << i));
      step(1'b0, 4'b1111, 4'b0000, 4'b1111, 32'h1312_1110);
      chk("rr_q", 32'(q), 32'(8'h10 + i));
      chk("rr_idle", 32'(gnt), 32'h0);
    end

    // locked sequence with requester 2 pending
    step(1'b1, 4'b0000, 4'b0000, 4'b0000, 32'h0);
    step(1'b0, 4'b0110, 4'b0010, 4'b0000, 32'h0);
    chk("lk_gnt0", 32'(gnt), 32'h2);
    for (int k = 0; k < 5; k++) begin
      step(1'b0, 4'b0110, 4'b0010, 4'b0010, 32'((8'h11 + k) << 8));
      chk("lk_gnt", 32'(gnt), 32'h2);
    end
    chk("lk_q", 32'(q), 32'h15);
    step(1'b0, 4'b0100, 4'b0000, 4'b0000, 32'h0);
    chk("lk_rel", 32'(gnt), 32'h0);
    step(1'b0, 4'b0100, 4'b0000, 4'b0000, 32'h0);
    chk("lk_next", 32'(gnt), 32'h4);

    // non-owner write, then reset mid-ownership
    step(1'b1, 4'b0000, 4'b0000, 4'b0000, 32'h0);
    step(1'b0, 4'b0001, 4'b0001, 4'b1000, 32'hFF00_0000);
    chk("no_gnt", 32'(gnt), 32'h1);
    step(1'b0, 4'b0001, 4'b0001, 4'b1000, 32'hFF00_0000);
    chk("no_q", 32'(q), 32'h0);
    chk("no_qv", 32'(q_valid), 32'h0);
    step(1'b1, 4'b0001, 4'b0001, 4'b0000, 32'h0);
    chk("mr_gnt", 32'(gnt), 32'h0);
    step(1'b0, 4'b1111, 4'b0000, 4'b0000, 32'h0);
    chk("mr_first", 32'(gnt), 32'h1);

    // long lock on requester 2 with requester 3 pending
    begin
      int hi = 0;
      int evts = 0;
      int last_hi = -1;
      int g3 = -1;
      step(1'b1, 4'b0000, 4'b0000, 4'b0000, 32'h0);
      for (int k = 0; k < 22; k++) begin
        step(1'b0, 4'b1100, 4'b0100, 4'b0000, 32'h0);
        if (gnt[2]) begin
          hi++;
          last_hi = k;
        end
        if (timeout_evt) evts++;
        if (gnt == 4'b1000 && g3 < 0) g3 = k;
      end
      if (TMO_EN) begin
        chk("to_len", 32'(hi), 32'd16);
        chk("to_evt", 32'(evts), 32'd1);
        chk("to_next", 32'(g3 - last_hi), 32'd2);
      end else begin
        chk("lk_len", 32'(hi), 32'd22);
        chk("lk_evt", 32'(evts), 32'd0);
      end
    end

    // randomized traffic with persistent requests
    begin
      logic [3:0] rq = 4'b0000;
      logic [3:0] lk = 4'b0000;
      for (int n = 0; n < 600; n++) begin
        rq = rq ^ (4'($urandom) & 4'($urandom) & 4'($urandom));
        if ($urandom_range(0, 7) == 0) lk = 4'($urandom);
        step(($urandom_range(0, 60) == 0), rq, lk,
             4'($urandom) & 4'($urandom), $urandom);
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
